// File: rtl/mul_share_arbiter_tt_pkg.sv
// Shared definitions for the taint-tracked multiplier-sharing arbiter.
package mul_share_arbiter_tt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  function automatic int default_timeout(input int width);
    return 2 * width + 4;
  endfunction

  function automatic int idx_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/mul_share_arbiter_tt_if.sv
// Requester and multiplier bus of the arbiter; slave is the arbiter's view.
interface mul_share_arbiter_tt_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2
);
  logic [NREQ-1:0]       req, req_t;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ-1:0]       req_a_t, req_b_t;
  logic [NREQ-1:0]       ack;
  logic                  ack_t;
  logic [NREQ-1:0]       rsp_valid;
  logic                  rsp_valid_t, rsp_product_t;
  logic [2*WIDTH-1:0]    rsp_product;
  logic                  mul_start, mul_start_t;
  logic [WIDTH-1:0]      mul_md, mul_mr;
  logic                  mul_md_t, mul_mr_t;
  logic                  mul_done, mul_done_t;
  logic [2*WIDTH-1:0]    mul_product;
  logic                  mul_product_t;
  logic                  busy, err;

  modport slave (
    input  req, req_t, req_a, req_b, req_a_t, req_b_t,
           mul_done, mul_done_t, mul_product, mul_product_t,
    output ack, ack_t, rsp_valid, rsp_valid_t, rsp_product, rsp_product_t,
           mul_start, mul_start_t, mul_md, mul_mr, mul_md_t, mul_mr_t, busy, err
  );

  modport master (
    output req, req_t, req_a, req_b, req_a_t, req_b_t,
           mul_done, mul_done_t, mul_product, mul_product_t,
    input  ack, ack_t, rsp_valid, rsp_valid_t, rsp_product, rsp_product_t,
           mul_start, mul_start_t, mul_md, mul_mr, mul_md_t, mul_mr_t, busy, err
  );
endinterface

// File: rtl/mul_share_arbiter_tt_rr_pick_tt.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module rr_pick_tt #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_req_t,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_vld,
  output logic            o_dec_t
);
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!o_vld && i_req[(int'(i_ptr) + i) % NREQ]) begin
        o_vld                            = 1'b1;
        o_idx                            = IW'((int'(i_ptr) + i) % NREQ);
        o_gnt[(int'(i_ptr) + i) % NREQ]  = 1'b1;
      end
    end
  end

  // Every request bit shapes the decision, so any tainted bit taints it.
  assign o_dec_t = |i_req_t;
endmodule

// File: rtl/mul_share_arbiter_tt.sv
// Shares one fixed-latency taint-tracked multiplier among NREQ requesters,
// round-robin, with a watchdog on the multiplier's productDone.
module mul_share_arbiter_tt
  import mul_share_arbiter_tt_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = default_timeout(WIDTH)
) (
  input logic clk,
  input logic rst,
  mul_share_arbiter_tt_if.slave bus
);
  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e            r_state, w_next;
  logic [IW-1:0]     r_ptr, r_owner, w_idx, w_ptr_nxt;
  logic [NREQ-1:0]   r_own_oh, w_gnt, w_ack, w_rsp;
  logic              w_vld, w_dec_t, w_tmo;
  logic              r_owner_t, r_md_t, r_mr_t, r_done_t, r_prod_t, r_err;
  logic [WIDTH-1:0]  r_a, r_b;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]     r_cnt;

  rr_pick_tt #(.NREQ(NREQ), .IW(IW)) u_pick (
    .i_req   (bus.req),
    .i_req_t (bus.req_t),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_vld   (w_vld),
    .o_dec_t (w_dec_t)
  );

  assign w_ptr_nxt = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + IW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // r_cnt is 0 in the first WAIT cycle, so hitting TIMEOUT-2 means TIMEOUT
  // cycles have elapsed since mul_start when err becomes visible.
  always_comb begin
    w_next = r_state;
    w_tmo  = 1'b0;
    w_ack  = '0;
    w_rsp  = '0;
    case (r_state)
      IDLE:  if (w_vld) w_next = ISSUE;
      ISSUE: begin
        w_ack  = r_own_oh;
        w_next = WAIT;
      end
      WAIT: begin
        if (bus.mul_done) w_next = RESP;
        else if (r_cnt == CW'(TIMEOUT - 2)) begin
          w_tmo  = 1'b1;
          w_next = IDLE;
        end
      end
      RESP: begin
        w_rsp  = r_own_oh;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr     <= '0;
      r_owner   <= '0;
      r_own_oh  <= '0;
      r_owner_t <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_md_t    <= 1'b0;
      r_mr_t    <= 1'b0;
      r_done_t  <= 1'b0;
      r_prod    <= '0;
      r_prod_t  <= 1'b0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_vld) begin
          r_owner   <= w_idx;
          r_own_oh  <= w_gnt;
          r_owner_t <= w_dec_t;
          r_a       <= bus.req_a[int'(w_idx)*WIDTH +: WIDTH];
          r_b       <= bus.req_b[int'(w_idx)*WIDTH +: WIDTH];
          r_md_t    <= bus.req_a_t[w_idx] | w_dec_t;
          r_mr_t    <= bus.req_b_t[w_idx] | w_dec_t;
          r_done_t  <= 1'b0;
        end
        ISSUE: r_cnt <= '0;
        WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (bus.mul_done) begin
            r_prod   <= bus.mul_product;
            r_prod_t <= bus.mul_product_t | r_md_t | r_mr_t;
            r_done_t <= bus.mul_done_t;
          end else if (w_tmo) begin
            r_err     <= 1'b1;
            r_ptr     <= w_ptr_nxt;
            r_owner_t <= 1'b0;
          end
        end
        RESP: begin
          r_ptr     <= w_ptr_nxt;
          r_owner_t <= 1'b0;
          r_done_t  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.ack           = w_ack;
  assign bus.ack_t         = r_owner_t;
  assign bus.mul_start     = (r_state == ISSUE);
  assign bus.mul_start_t   = r_owner_t;
  assign bus.mul_md        = r_a;
  assign bus.mul_mr        = r_b;
  assign bus.mul_md_t      = r_md_t;
  assign bus.mul_mr_t      = r_mr_t;
  assign bus.rsp_valid     = w_rsp;
  assign bus.rsp_valid_t   = r_owner_t | r_done_t;
  assign bus.rsp_product   = r_prod;
  assign bus.rsp_product_t = r_prod_t;
  assign bus.busy          = (r_state != IDLE);
  assign bus.err           = r_err;
endmodule

// File: tb/tb_mul_share_arbiter_tt.sv
// Bench for mul_share_arbiter_tt: vector table, corner sequences, random vs model.
module tb_mul_share_arbiter_tt;
  localparam int W   = 4;
  localparam int N   = 2;
  localparam int LAT = 2 * W + 2;

  typedef struct {
    logic [1:0] rq, rt, at, bt;
    logic [3:0] a0, b0, a1, b1;
    int         own;
    logic [7:0] p;
    logic       ackt, mdt, mrt, rvt, pt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   ncmp = 0, nbad = 0, cyc = 0, mcnt = 0;
  logic stuck = 1'b0, dn_t = 1'b0;
  logic [7:0] mprod = '0;
  logic mprod_t = 1'b0;

  mul_share_arbiter_tt_if #(.WIDTH(W), .NREQ(N)) bus();
  mul_share_arbiter_tt #(.WIDTH(W), .NREQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // One clock; also plays the fixed-latency multiplier.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    bus.mul_done   = 1'b0;
    bus.mul_done_t = 1'b0;
    if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0 && !stuck) begin
        bus.mul_done      = 1'b1;
        bus.mul_done_t    = dn_t;
        bus.mul_product   = mprod;
        bus.mul_product_t = mprod_t;
      end
    end
    if (bus.mul_start === 1'b1) begin
      mcnt    = LAT;
      mprod   = 8'(bus.mul_md) * 8'(bus.mul_mr);
      mprod_t = bus.mul_md_t | bus.mul_mr_t;
    end
  endtask

  task automatic txn(input string nm, input vec_t v);
    int n0, ta, tr;
    logic [1:0] oh;
    oh = 2'b01 << v.own;
    bus.req = v.rq; bus.req_t = v.rt;
    bus.req_a = {v.a1, v.a0}; bus.req_b = {v.b1, v.b0};
    bus.req_a_t = v.at; bus.req_b_t = v.bt;
    n0 = cyc; ta = -1; tr = -1;
    for (int k = 0; k < 40 && tr < 0; k++) begin
      tick();
      if (bus.ack != 0 && ta < 0) begin
        ta = cyc;
        chk($sformatf("%s ack", nm), bus.ack, oh);
        chk($sformatf("%s ack_cycle", nm), ta - n0, 1);
        chk($sformatf("%s ack_t", nm), bus.ack_t, v.ackt);
        chk($sformatf("%s mul_start", nm), bus.mul_start, 1);
        chk($sformatf("%s mul_start_t", nm), bus.mul_start_t, v.ackt);
        bus.req[v.own] = 1'b0;
      end else if (ta >= 0 && cyc == ta + 1) begin
        chk($sformatf("%s mul_md_t", nm), bus.mul_md_t, v.mdt);
        chk($sformatf("%s mul_mr_t", nm), bus.mul_mr_t, v.mrt);
      end
      if (bus.rsp_valid != 0) begin
        tr = cyc;
        chk($sformatf("%s rsp_valid", nm), bus.rsp_valid, oh);
        chk($sformatf("%s rsp_cycle", nm), tr - n0, 2 * W + 4);
        chk($sformatf("%s rsp_product", nm), bus.rsp_product, v.p);
        chk($sformatf("%s rsp_product_t", nm), bus.rsp_product_t, v.pt);
        chk($sformatf("%s rsp_valid_t", nm), bus.rsp_valid_t, v.rvt);
      end
    end
    if (tr < 0) begin
      ncmp++; nbad++;
      $display("FAIL %s no_response: got none within 40 cycles, want rsp_valid", nm);
    end
    tick();
    chk($sformatf("%s idle_after", nm), bus.busy, 0);
    chk($sformatf("%s product_held", nm), bus.rsp_product, v.p);
  endtask

  vec_t tbl[8];
  vec_t v;

  initial begin
    int ta, m_ptr, own;
    logic saw_rsp;
    logic [3:0] av[2], bv[2];

    tbl[0] = '{2'b11, 2'b00, 2'b00, 2'b00, 4'd2, 4'd7, 4'd15, 4'd15, 0, 8'd14,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{2'b11, 2'b00, 2'b00, 2'b00, 4'd2, 4'd7, 4'd15, 4'd15, 1, 8'd225, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{2'b11, 2'b00, 2'b00, 2'b00, 4'd5, 4'd3, 4'd1,  4'd1,  0, 8'd15,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{2'b01, 2'b00, 2'b00, 2'b00, 4'd5, 4'd3, 4'd0,  4'd0,  0, 8'd15,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{2'b10, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 4'd3,  4'd4,  1, 8'd12,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{2'b11, 2'b10, 2'b00, 2'b00, 4'd6, 4'd7, 4'd1,  4'd1,  0, 8'd42,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{2'b01, 2'b00, 2'b01, 2'b00, 4'd9, 4'd9, 4'd0,  4'd0,  0, 8'd81,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{2'b10, 2'b00, 2'b00, 2'b10, 4'd0, 4'd0, 4'd15, 4'd1,  1, 8'd15,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    bus.req = '0; bus.req_t = '0; bus.req_a = '0; bus.req_b = '0;
    bus.req_a_t = '0; bus.req_b_t = '0;
    bus.mul_done = 1'b0; bus.mul_done_t = 1'b0;
    bus.mul_product = '0; bus.mul_product_t = 1'b0;

    repeat (3) tick();
    chk("reset busy", bus.busy, 0);
    chk("reset ack", bus.ack, 0);
    chk("reset mul_start", bus.mul_start, 0);
    chk("reset err", bus.err, 0);
    chk("reset rsp_product", bus.rsp_product, 0);
    chk("reset taints", {bus.ack_t, bus.mul_md_t, bus.mul_mr_t, bus.rsp_valid_t, bus.rsp_product_t}, 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) txn($sformatf("vec%0d", i), tbl[i]);

    // Multiplier never answers: watchdog fires, no response, ptr moves on.
    stuck = 1'b1;
    bus.req = 2'b01; bus.req_t = '0; bus.req_a_t = '0; bus.req_b_t = '0;
    bus.req_a = {4'd1, 4'd3}; bus.req_b = {4'd1, 4'd3};
    ta = -1; saw_rsp = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.rsp_valid != 0) saw_rsp = 1'b1;
      if (bus.ack != 0 && ta < 0) begin
        ta = cyc;
        bus.req = '0;
      end
      if (ta >= 0 && cyc == ta + 11) chk("tmo err_early", bus.err, 0);
      if (ta >= 0 && cyc == ta + 12) begin
        chk("tmo err", bus.err, 1);
        chk("tmo idle", bus.busy, 0);
        break;
      end
    end
    chk("tmo ack_seen", ta >= 0, 1);
    chk("tmo no_rsp", saw_rsp, 0);
    stuck = 1'b0;
    v = '{2'b11, 2'b00, 2'b00, 2'b00, 4'd4, 4'd4, 4'd11, 4'd13, 1, 8'd143, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    txn("after_tmo", v);
    v = '{2'b01, 2'b00, 2'b00, 2'b00, 4'd8, 4'd8, 4'd0, 4'd0, 0, 8'd64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    txn("ptr_to_1", v);

    // Reset while waiting on the multiplier.
    bus.req = 2'b01; bus.req_a = {4'd0, 4'd7}; bus.req_b = {4'd0, 4'd7}; bus.req_a_t = 2'b01;
    ta = -1;
    for (int k = 0; k < 10 && ta < 0; k++) begin
      tick();
      if (bus.ack != 0) begin ta = cyc; bus.req = '0; end
    end
    chk("rstw ack_seen", ta >= 0, 1);
    repeat (3) tick();
    chk("rstw busy_before", bus.busy, 1);
    rst = 1'b0;
    #2;
    chk("rstw busy", bus.busy, 0);
    chk("rstw err", bus.err, 0);
    chk("rstw mul_md", bus.mul_md, 0);
    chk("rstw taints", {bus.ack_t, bus.mul_start_t, bus.mul_md_t, bus.mul_mr_t}, 0);
    chk("rstw rsp_product", bus.rsp_product, 0);
    mcnt = 0;
    bus.req_a_t = '0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    bus.mul_done = 1'b1; bus.mul_product = 8'hAA; bus.mul_product_t = 1'b1;
    tick();
    chk("idle_done busy", bus.busy, 0);
    chk("idle_done rsp_valid", bus.rsp_valid, 0);
    chk("idle_done rsp_product", bus.rsp_product, 0);
    v = '{2'b11, 2'b00, 2'b00, 2'b00, 4'd12, 4'd10, 4'd3, 4'd3, 0, 8'd120, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    txn("post_rst", v);

    // Random traffic against a rule-level model of arbitration and taint.
    m_ptr = 1;
    for (int t = 0; t < 24; t++) begin
      v.rq = 2'($urandom_range(1, 3));
      v.rt = 2'($urandom_range(0, 3));
      v.at = 2'($urandom_range(0, 3));
      v.bt = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
        av[i] = 4'($urandom_range(0, 15));
        bv[i] = 4'($urandom_range(0, 15));
      end
      dn_t = 1'($urandom_range(0, 1));
      v.a0 = av[0]; v.b0 = bv[0]; v.a1 = av[1]; v.b1 = bv[1];
      own = -1;
      for (int i = 0; i < N; i++)
        if (own < 0 && v.rq[(m_ptr + i) % N]) own = (m_ptr + i) % N;
      v.own  = own;
      v.p    = 8'(av[own]) * 8'(bv[own]);
      v.ackt = |v.rt;
      v.mdt  = v.at[own] | v.ackt;
      v.mrt  = v.bt[own] | v.ackt;
      v.rvt  = v.ackt | dn_t;
      v.pt   = v.mdt | v.mrt;
      m_ptr  = (own + 1) % N;
      txn($sformatf("rnd%0d", t), v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule

// File: doc/mul_share_arbiter_tt.md
# mul_share_arbiter_tt

Round-robin arbiter and sequencer that shares one taint-tracked sequential multiplier (operand registers plus control FSM, fixed latency) among NREQ requesters. It captures the winning requester's operands, pulses the multiplier start, waits for productDone, and returns the product to the owner. Word-level taint propagates through every decision. Transaction timing is independent of operand values, so constant-time properties of the multiplier are preserved.

## Interface
- WIDTH, 4: operand width; product is 2*WIDTH
- NREQ, 2: number of requesters (≥2)
- TIMEOUT, 2*WIDTH+4: max cycles from mul_start to mul_done before error
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  request level per requester; held until ack
- req_t  in  NREQ  taint of each req bit
- req_a, req_b  in  NREQ*WIDTH  packed operands; slot i at [i*WIDTH +: WIDTH]
- req_a_t, req_b_t  in  NREQ  word taint per operand slot
- ack  out  NREQ  one-hot, one-cycle pulse; operands captured
- ack_t  out  1  taint of ack
- rsp_valid  out  NREQ  one-hot, one-cycle pulse; rsp_product valid
- rsp_valid_t, rsp_product_t  out  1  response taints
- rsp_product  out  2*WIDTH  product, held until next response
- mul_start, mul_start_t  out  1  start pulse to multiplier and its taint
- mul_md, mul_mr  out  WIDTH  multiplicand/multiplier operands
- mul_md_t, mul_mr_t  out  1  operand taints
- mul_done, mul_done_t  in  1  productDone from multiplier and its taint
- mul_product  in  2*WIDTH  multiplier result; mul_product_t  in  1
- busy  out  1  high outside IDLE
- err  out  1  sticky timeout flag; cleared only by reset

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: when any req is set, select the first set bit at or after rr_ptr (wrapping); latch owner index, operands, and taints; go to ISSUE. With no requests, stay in IDLE.
- ISSUE (1 cycle): mul_start=1, ack[owner]=1; clear the watchdog counter; go to WAIT.
- WAIT: hold mul_md/mul_mr stable. On mul_done: latch mul_product, go to RESP. If the counter reaches TIMEOUT: set err, go to IDLE without a response, advance rr_ptr.
- RESP (1 cycle): rsp_valid[owner]=1; rr_ptr = owner+1 mod NREQ; go to IDLE.
- Taint:
  - dec_t = OR of all req_t, sampled at the IDLE decision.
  - owner_t = dec_t; it is sticky for the transaction and cleared on return to IDLE.
  - ack_t = mul_start_t = owner_t.
  - mul_md_t = req_a_t[owner] | owner_t; mul_mr_t = req_b_t[owner] | owner_t.
  - rsp_valid_t = owner_t | mul_done_t; rsp_product_t = mul_product_t | mul_md_t | mul_mr_t.
- Reset (any state, including mid-WAIT): state=IDLE, rr_ptr=0, all outputs and taints 0, err=0, rsp_product=0. An in-flight product is discarded. Reset the multiplier together with this block.
- A req dropped before ack has no effect once latched. The transaction completes anyway.

## Timing
- Decision in IDLE at cycle N. ack and mul_start pulse at N+1. With the team multiplier, mul_done arrives at N+1+(2*WIDTH+2) and rsp_valid at N+2*WIDTH+4.
- Back-to-back: the next decision can occur in the cycle after RESP. Minimum period is 2*WIDTH+5 cycles per transaction.
- Latency does not depend on operand values or on which requester wins.
- A mul_done arriving in IDLE, ISSUE, or RESP is ignored.

## Structure
- Shared package: state encoding constants (IDLE=0, ISSUE=1, WAIT=2, RESP=3), the default-TIMEOUT function, and a clog2-based index width for NREQ.
- One sub-module: rr_pick_tt, a combinational round-robin priority picker that takes req, req_t, and rr_ptr and returns a one-hot grant, an index, a valid flag, and dec_t.

## Test plan
- Single request, WIDTH=4, req=01, a0=5, b0=3, no taint: ack=01 at N+1, rsp_valid=01 at N+12 with rsp_product=15, all _t=0.
- Simultaneous req=11 from reset: requester 0 served first, then requester 1. Check rr_ptr=0 after the second response. Operands a1=15, b1=15 give 225.
- Taint on the losing requester: req_t=10, req=11. Requester 0 wins, but ack_t=mul_start_t=rsp_valid_t=1. Response timing is identical to the untainted case.
- Tainted operand a0 (req_a_t=01): mul_md_t=1, mul_mr_t=0, rsp_product_t=1, rsp_valid_t=0.
- Multiplier stuck (mul_done held 0): err rises TIMEOUT=12 cycles after mul_start. No rsp_valid is issued, and the block returns to IDLE to serve the next request.
- rst asserted mid-WAIT: outputs go to 0 asynchronously. After release, a new req=01 is served normally with rr_ptr=0.
